// File: rtl/lockin_pkg.sv
// Shared constants and state encoding for the lock-in display decimator.
// Both the top level and the boxcar lanes import this package.
package lockin_pkg;

    localparam int CORDIC_WIDTH_DEF = 42;
    localparam int LOG2_N_DEF       = 10;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } lockin_state_e;

endpackage

// File: rtl/lockin_boxcar_acc.sv
// One accumulate-and-dump lane: sums N samples and registers the floored
// block mean on the edge that accepts the last sample of the block.
module lockin_boxcar_acc
    import lockin_pkg::*;
#(
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
    parameter int LOG2_N       = LOG2_N_DEF,
    parameter bit SIGNED       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    accept_i,
    input  logic                    dump_i,
    input  logic [CORDIC_WIDTH-1:0] sample_i,
    output logic [CORDIC_WIDTH-1:0] mean_o
);

    localparam int AW = CORDIC_WIDTH + LOG2_N;

    logic [AW-1:0]           acc_q;
    logic [AW-1:0]           acc_d;
    logic [CORDIC_WIDTH-1:0] mean_q;
    logic [CORDIC_WIDTH-1:0] mean_d;
    logic [AW-1:0]           sample_ext_s;
    logic [AW-1:0]           sum_s;
    logic [AW-1:0]           shifted_s;

    // Extend the sample, form the running sum and its shifted mean.
    always_comb begin
        sample_ext_s = '0;
        shifted_s    = '0;
        if (SIGNED) begin
            sample_ext_s = {{LOG2_N{sample_i[CORDIC_WIDTH-1]}}, sample_i};
        end else begin
            sample_ext_s = {{LOG2_N{1'b0}}, sample_i};
        end
        sum_s = acc_q + sample_ext_s;
        // Arithmetic shift floors toward -inf for the signed lane.
        if (SIGNED) begin
            shifted_s = AW'($signed(sum_s) >>> LOG2_N);
        end else begin
            shifted_s = sum_s >> LOG2_N;
        end
    end

    // Next-state for accumulator and held mean.
    always_comb begin
        acc_d  = acc_q;
        mean_d = mean_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accept_i && dump_i) begin
            acc_d  = '0;
            mean_d = shifted_s[CORDIC_WIDTH-1:0];
        end else if (accept_i) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Lane registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            mean_q <= '0;
        end else begin
            acc_q  <= acc_d;
            mean_q <= mean_d;
        end
    end

    assign mean_o = mean_q;

endmodule

// File: rtl/lockin_display_decimator.sv
// Block-averaging decimator for CORDIC magnitude/phase: emits one mean pair
// per 2^LOG2_N accepted samples, with freeze and clear controls.
module lockin_display_decimator
    import lockin_pkg::*;
#(
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
    parameter int LOG2_N       = LOG2_N_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [CORDIC_WIDTH-1:0] i_magnitude,
    input  logic [CORDIC_WIDTH-1:0] i_phase,
    input  logic                    i_freeze,
    input  logic                    i_clear,
    output logic                    o_valid,
    output logic [CORDIC_WIDTH-1:0] o_magnitude,
    output logic [CORDIC_WIDTH-1:0] o_phase,
    output logic [LOG2_N-1:0]       o_fill
);

    lockin_state_e     state_q;
    lockin_state_e     state_d;
    logic [LOG2_N-1:0] fill_q;
    logic [LOG2_N-1:0] fill_d;
    logic              accept_s;
    logic              last_s;

    // Clear dominates both valid and freeze.
    assign accept_s = i_valid & ~i_freeze & ~i_clear;
    assign last_s   = accept_s & (fill_q == {LOG2_N{1'b1}});

    // Fill counter wraps to zero naturally on the Nth sample.
    always_comb begin
        fill_d = fill_q;
        if (i_clear) begin
            fill_d = '0;
        end else if (accept_s) begin
            fill_d = fill_q + LOG2_N'(1);
        end else begin
            fill_d = fill_q;
        end
    end

    // FSM next state; EMIT lasts one cycle and needs no accept gating.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (last_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_EMIT:  state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    lockin_boxcar_acc #(
        .CORDIC_WIDTH (CORDIC_WIDTH),
        .LOG2_N       (LOG2_N),
        .SIGNED       (1'b0)
    ) u_mag_lane (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (i_clear),
        .accept_i (accept_s),
        .dump_i   (last_s),
        .sample_i (i_magnitude),
        .mean_o   (o_magnitude)
    );

    lockin_boxcar_acc #(
        .CORDIC_WIDTH (CORDIC_WIDTH),
        .LOG2_N       (LOG2_N),
        .SIGNED       (1'b1)
    ) u_phs_lane (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (i_clear),
        .accept_i (accept_s),
        .dump_i   (last_s),
        .sample_i (i_phase),
        .mean_o   (o_phase)
    );

    assign o_valid = (state_q == ST_EMIT);
    assign o_fill  = fill_q;

endmodule

// File: tb/tb_lockin_display_decimator.sv
// Directed bench for lockin_display_decimator with CORDIC_WIDTH=42, LOG2_N=2.
module tb_lockin_display_decimator;

    localparam int W = 42;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [W-1:0] i_magnitude;
    logic [W-1:0] i_phase;
    logic         i_freeze;
    logic         i_clear;
    logic         o_valid;
    logic [W-1:0] o_magnitude;
    logic [W-1:0] o_phase;
    logic [L-1:0] o_fill;

    int n_tests = 0;
    int n_fail  = 0;

    lockin_display_decimator #(.CORDIC_WIDTH(W), .LOG2_N(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_magnitude (i_magnitude),
        .i_phase     (i_phase),
        .i_freeze    (i_freeze),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_magnitude (o_magnitude),
        .o_phase     (o_phase),
        .o_fill      (o_fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Apply inputs, take one clock edge, sample 1 time unit later.
    task automatic cyc(input logic v, input longint m, input longint p,
                       input logic f, input logic c, input logic r);
        i_valid     = v;
        i_magnitude = W'(m);
        i_phase     = W'(p);
        i_freeze    = f;
        i_clear     = c;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ph(input longint p);
        logic [W-1:0] t;
        t = W'(p);
        return {22'd0, t};
    endfunction

    int strobes;
    int pos[$];

    initial begin
        // Reset
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 5, 5, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_mag",   64'(o_magnitude), 64'd0);
        chk("rst_phase", 64'(o_phase), 64'd0);
        chk("rst_fill",  64'(o_fill), 64'd0);

        // Magnitudes 4,8,12,16 with phases -3,-3,-3,-2
        cyc(1'b1, 4, -3, 1'b0, 1'b0, 1'b0);
        chk("m1_fill", 64'(o_fill), 64'd1);
        chk("m1_valid", 64'(o_valid), 64'd0);
        cyc(1'b1, 8, -3, 1'b0, 1'b0, 1'b0);
        chk("m2_fill", 64'(o_fill), 64'd2);
        cyc(1'b1, 12, -3, 1'b0, 1'b0, 1'b0);
        chk("m3_fill", 64'(o_fill), 64'd3);
        chk("m3_valid", 64'(o_valid), 64'd0);
        cyc(1'b1, 16, -2, 1'b0, 1'b0, 1'b0);
        chk("m4_valid", 64'(o_valid), 64'd1);
        chk("m4_mag",   64'(o_magnitude), 64'd10);
        chk("m4_phase", 64'(o_phase), ph(-3));
        chk("m4_fill",  64'(o_fill), 64'd0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("hold_valid", 64'(o_valid), 64'd0);
        chk("hold_mag",   64'(o_magnitude), 64'd10);
        chk("hold_phase", 64'(o_phase), ph(-3));

        // Phases 5,5,5,6 -> 21 >>> 2 = 5
        cyc(1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 0, 6, 1'b0, 1'b0, 1'b0);
        chk("p5_valid", 64'(o_valid), 64'd1);
        chk("p5_phase", 64'(o_phase), ph(5));
        chk("p5_mag",   64'(o_magnitude), 64'd0);

        // 12 continuous samples 1..12 -> strobes after samples 4, 8, 12
        strobes = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b1, longint'(k + 1), 0, 1'b0, 1'b0, 1'b0);
            if (o_valid) begin
                strobes++;
                pos.push_back(k);
            end
        end
        chk("bb_count", 64'(strobes), 64'd3);
        chk("bb_last_mag", 64'(o_magnitude), 64'd10);
        if (pos.size() == 3) begin
            chk("bb_pos0", 64'(pos[0]), 64'd3);
            chk("bb_pos1", 64'(pos[1]), 64'd7);
            chk("bb_pos2", 64'(pos[2]), 64'd11);
        end else begin
            chk("bb_pos_size", 64'(pos.size()), 64'd3);
        end
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("bb_idle_valid", 64'(o_valid), 64'd0);

        // Freeze: 2,2, five frozen 100s, then 6,6 -> mean 4
        strobes = 0;
        cyc(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 100, 100, 1'b1, 1'b0, 1'b0);
            if (o_valid) strobes++;
        end
        chk("frz_fill", 64'(o_fill), 64'd2);
        chk("frz_mag_held", 64'(o_magnitude), 64'd10);
        cyc(1'b1, 6, 0, 1'b0, 1'b0, 1'b0);
        if (o_valid) strobes++;
        cyc(1'b1, 6, 0, 1'b0, 1'b0, 1'b0);
        if (o_valid) strobes++;
        chk("frz_valid", 64'(o_valid), 64'd1);
        chk("frz_mag", 64'(o_magnitude), 64'd4);
        chk("frz_phase", 64'(o_phase), ph(0));
        chk("frz_strobes", 64'(strobes), 64'd1);

        // Clear with simultaneous valid: sample dropped, mean retained
        cyc(1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
        chk("clr_pre_fill", 64'(o_fill), 64'd3);
        cyc(1'b1, 50, 50, 1'b0, 1'b1, 1'b0);
        chk("clr_fill", 64'(o_fill), 64'd0);
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_mag", 64'(o_magnitude), 64'd4);
        cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        chk("clr_3_valid", 64'(o_valid), 64'd0);
        cyc(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        chk("clr_4_valid", 64'(o_valid), 64'd1);
        chk("clr_4_mag", 64'(o_magnitude), 64'd1);

        // Reset mid-block discards the partial sum
        cyc(1'b1, 9, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9, 9, 1'b0, 1'b0, 1'b1);
        chk("mrst_valid", 64'(o_valid), 64'd0);
        chk("mrst_mag",   64'(o_magnitude), 64'd0);
        chk("mrst_phase", 64'(o_phase), 64'd0);
        chk("mrst_fill",  64'(o_fill), 64'd0);
        cyc(1'b1, 8, -1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8, -1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8, -1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_3_valid", 64'(o_valid), 64'd0);
        chk("post_rst_3_fill", 64'(o_fill), 64'd3);
        cyc(1'b1, 8, -1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_4_valid", 64'(o_valid), 64'd1);
        chk("post_rst_4_mag", 64'(o_magnitude), 64'd8);
        chk("post_rst_4_phase", 64'(o_phase), ph(-1));
        cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lockin_display_decimator.md
LOCKIN_DISPLAY_DECIMATOR -- requirements
Module: lockin_display_decimator

Interface
REQ-001 SHALL have parameter CORDIC_WIDTH, default 42: width of magnitude/phase samples.
REQ-002 SHALL have parameter LOG2_N, default 10: log2 of samples averaged per output (N = 2^LOG2_N), legal range 1..16.
REQ-003 SHALL have port clk  input  1: single clock, shared with the display-RAM write side.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1: CORDIC sample strobe, one sample per high cycle.
REQ-006 SHALL have port i_magnitude  input  CORDIC_WIDTH: unsigned magnitude sample.
REQ-007 SHALL have port i_phase  input  CORDIC_WIDTH: signed two's-complement phase sample.
REQ-008 SHALL have port i_freeze  input  1: hold display; samples ignored while high.
REQ-009 SHALL have port i_clear  input  1: discard the partial block.
REQ-010 SHALL have port o_valid  output  1: single-cycle strobe, one per completed block.
REQ-011 SHALL have port o_magnitude  output  CORDIC_WIDTH: block mean of magnitude.
REQ-012 SHALL have port o_phase  output  CORDIC_WIDTH: signed block mean of phase.
REQ-013 SHALL have port o_fill  output  LOG2_N: samples accepted in the current block.

Function
REQ-014 SHALL accept a sample on a clk edge iff i_valid=1, i_freeze=0, i_clear=0.
REQ-015 SHALL accumulate magnitude unsigned and phase signed in CORDIC_WIDTH+LOG2_N-bit accumulators; no overflow is possible.
REQ-016 SHALL increment o_fill per accepted sample; wraps N-1 -> 0 on the Nth accepted sample.
REQ-017 SHALL, on the edge accepting the Nth sample, register o_magnitude = (mag_acc + sample) >> LOG2_N (logical) and o_phase = (phs_acc + sample) >>> LOG2_N (arithmetic, floor toward -inf), and assert o_valid for exactly that following cycle (latency 1 clk).
REQ-018 SHALL, on that same edge, load both accumulators with zero so the next accepted sample starts a new block; back-to-back i_valid every cycle yields one o_valid every N cycles with no lost sample.
REQ-019 SHALL hold o_magnitude/o_phase stable between o_valid strobes.
REQ-020 SHALL, while i_freeze=1, hold accumulators, o_fill and outputs and keep o_valid=0; the partial block resumes on deassertion.
REQ-021 SHALL, when i_clear=1, zero accumulators and o_fill on the next edge, leave o_magnitude/o_phase unchanged, keep o_valid=0; i_clear wins over simultaneous i_valid (sample dropped) and over i_freeze.
REQ-022 SHALL implement a two-state machine: ACCUM (collecting) and EMIT (one cycle, o_valid=1); EMIT returns to ACCUM unconditionally and still accepts a sample presented in that cycle as the first of the new block.
REQ-023 SHALL not average across phase wrap; samples straddling +/- full scale average arithmetically (documented limitation).

Reset
REQ-024 SHALL on rst=1 set state ACCUM, accumulators 0, o_fill 0, o_valid 0, o_magnitude 0, o_phase 0.
REQ-025 SHALL give rst priority over all inputs; a block in progress is discarded, first output after reset needs N fresh samples.

Structure
REQ-026 SHALL take CORDIC_WIDTH and LOG2_N defaults and the ACCUM/EMIT state encoding from shared package lockin_pkg.
REQ-027 SHALL instantiate sub-module lockin_boxcar_acc (one accumulate-and-dump lane, parameter SIGNED) twice: magnitude lane and phase lane; counter and FSM stay in the top.

Verification (bench uses CORDIC_WIDTH=42, LOG2_N=2)
REQ-028 SHALL cover: magnitudes 4,8,12,16 on consecutive i_valid -> o_valid one cycle after 4th sample, o_magnitude=10, o_fill back to 0.
REQ-029 SHALL cover: phases -3,-3,-3,-2 -> o_phase=-3 (sum -11 >>> 2 floors to -3); phases 5,5,5,6 -> o_phase=5.
REQ-030 SHALL cover: i_valid high for 12 continuous cycles -> exactly 3 o_valid strobes, spaced 4 cycles apart.
REQ-031 SHALL cover: 2 samples, i_freeze=1 for 5 cycles with i_valid=1, then 2 samples -> single o_valid; frozen samples absent from mean.
REQ-032 SHALL cover: 3 samples, then i_clear=1 together with i_valid=1 -> o_fill=0, no o_valid, previous o_magnitude retained; 4 new samples 1,1,1,1 -> o_magnitude=1.
REQ-033 SHALL cover: rst asserted after 3 samples -> all outputs 0 next cycle, next o_valid only after 4 post-reset samples.
